// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the instruction queue and its consumers.
package inst_queue_pkg;

   localparam int DEFAULT_INST_LEN = 128;
   localparam int DEFAULT_DEPTH    = 16;
   localparam int DEFAULT_CNT_W    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } loop_state_t;

   // Instruction field positions, decoded downstream of instruct.
   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 7;
   localparam int DST_LSB    = 8;
   localparam int DST_MSB    = 15;
   localparam int SRC0_LSB   = 16;
   localparam int SRC0_MSB   = 23;
   localparam int SRC1_LSB   = 24;
   localparam int SRC1_MSB   = 31;
   localparam int IMM_LSB    = 32;
   localparam int IMM_MSB    = 63;

endpackage

// File: rtl/inst_queue_ram.sv
// Instruction storage: synchronous write, registered read that holds between reads.
module inst_queue_ram #(
   parameter int INST_LEN = 128,
   parameter int DEPTH    = 16,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [INST_LEN-1:0] wr_data,
   input  logic                rd_en,
   input  logic [AW-1:0]       rd_addr,
   output logic [INST_LEN-1:0] rd_data
);

   logic [INST_LEN-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/inst_queue.sv
// Instruction FIFO with registered output; INSTQ_LOOP_EN adds a hardware loop that
// replays a body of entries a programmed number of times.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int INST_LEN                = DEFAULT_INST_LEN,
   parameter int DEPTH                   = DEFAULT_DEPTH,
   parameter int CNT_W                   = DEFAULT_CNT_W,
   parameter logic [INST_LEN-1:0] RST_INST = '0,
   localparam int PTR_W                  = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_wr,
   input  logic [INST_LEN-1:0] inst_wdata,
   output logic                inst_full,
   input  logic                inst_req,
   output logic [INST_LEN-1:0] instruct,
   output logic                inst_valid,
   output logic                inst_empty,
   output logic [PTR_W:0]      inst_count
`ifdef INSTQ_LOOP_EN
   ,
   input  logic                loop_start,
   input  logic [PTR_W:0]      loop_len,
   input  logic [CNT_W-1:0]    loop_times,
   output logic                loop_busy,
   output loop_state_t         loop_state
`endif
);

   localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);

   logic [PTR_W:0]      wr_ptr, rd_ptr, free_ptr, readable, stored, rd_inc;
   logic                do_wr, do_pop, loaded;
   logic [INST_LEN-1:0] ram_q;

   // Handshakes: a write is taken when inst_wr && !inst_full, a pop when
   // inst_req && !inst_empty; both flags come from pre-edge register state.
   assign readable   = wr_ptr - rd_ptr;
   assign stored     = wr_ptr - free_ptr;
   assign inst_empty = (readable == '0);
   assign inst_full  = (stored == DEPTH_P);
   assign inst_count = stored;
   assign do_wr      = inst_wr & ~inst_full;
   assign do_pop     = inst_req & ~inst_empty;
   assign rd_inc     = rd_ptr + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         inst_valid <= 1'b0;
         loaded     <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         inst_valid <= do_pop;
         if (do_pop) loaded <= 1'b1;
      end
   end

   // The RAM read register has no reset, so RST_INST is shown until the first pop.
   assign instruct = loaded ? ram_q : RST_INST;

`ifdef INSTQ_LOOP_EN
   loop_state_t      state, state_nx;
   logic [PTR_W:0]   head, len, pop_cnt;
   logic [CNT_W-1:0] remaining;
   logic             arm_ok, arm_fire, hold_free, body_done, restart, finish;

   assign arm_ok    = loop_start && (loop_len != '0) && (loop_len <= DEPTH_P) &&
                      (loop_times >= CNT_W'(2));
   assign body_done = do_pop && (state != IDLE) && ((pop_cnt + 1'b1) == len);
   assign restart   = body_done && (remaining != '0);
   assign finish    = body_done && (remaining == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (arm_ok) state_nx = ARMED;
         ARMED:   if (do_pop) state_nx = finish ? IDLE : RUN;
         RUN:     if (finish) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      loop_busy = (state != IDLE);
      arm_fire  = (state == IDLE) && arm_ok;
      hold_free = (state != IDLE) || arm_fire;
   end

   assign loop_state = state;

   // Body entries stay allocated (free_ptr parked at head) until the last pass ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         free_ptr  <= '0;
         head      <= '0;
         len       <= '0;
         pop_cnt   <= '0;
         remaining <= '0;
      end else begin
         if (restart)     rd_ptr <= head;
         else if (do_pop) rd_ptr <= rd_inc;

         if (finish)                     free_ptr <= rd_inc;
         else if (!hold_free && do_pop)  free_ptr <= rd_inc;

         if (arm_fire) begin
            head      <= rd_ptr;
            len       <= loop_len;
            remaining <= loop_times - 1'b1;
            pop_cnt   <= '0;
         end else if (body_done) begin
            pop_cnt <= '0;
            if (restart) remaining <= remaining - 1'b1;
         end else if (do_pop && (state != IDLE)) begin
            pop_cnt <= pop_cnt + 1'b1;
         end
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         rd_ptr <= '0;
      else if (do_pop) rd_ptr <= rd_inc;
   end

   assign free_ptr = rd_ptr;
`endif

   inst_queue_ram #(
      .INST_LEN (INST_LEN),
      .DEPTH    (DEPTH),
      .AW       (PTR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (do_wr),
      .wr_addr (wr_ptr[PTR_W-1:0]),
      .wr_data (inst_wdata),
      .rd_en   (do_pop),
      .rd_addr (rd_ptr[PTR_W-1:0]),
      .rd_data (ram_q)
   );

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: queue-based reference model checked every cycle, plus directed
// literal checks. Loop scenarios are compiled in when INSTQ_LOOP_EN is defined.
module tb_inst_queue;

   localparam int W     = 128;
   localparam int DEPTH = 16;
   localparam int PTR_W = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             inst_wr, inst_req;
   logic [W-1:0]     inst_wdata;
   logic             inst_full, inst_valid, inst_empty;
   logic [W-1:0]     instruct;
   logic [PTR_W:0]   inst_count;
`ifdef INSTQ_LOOP_EN
   logic             loop_start;
   logic [PTR_W:0]   loop_len;
   logic [CNT_W-1:0] loop_times;
   logic             loop_busy;
   inst_queue_pkg::loop_state_t loop_state;
`endif

   always #5 clk = ~clk;

   inst_queue dut (
      .clk        (clk),
      .rst        (rst),
      .inst_wr    (inst_wr),
      .inst_wdata (inst_wdata),
      .inst_full  (inst_full),
      .inst_req   (inst_req),
      .instruct   (instruct),
      .inst_valid (inst_valid),
      .inst_empty (inst_empty),
      .inst_count (inst_count)
`ifdef INSTQ_LOOP_EN
      ,
      .loop_start (loop_start),
      .loop_len   (loop_len),
      .loop_times (loop_times),
      .loop_busy  (loop_busy),
      .loop_state (loop_state)
`endif
   );

   // ---------------- reference model ----------------
   logic [W-1:0] exp_q[$];   // readable entries, oldest first
   logic [W-1:0] body_q[$];  // loop body entries already popped in this pass
   logic [W-1:0] exp_instruct;
   logic         exp_valid;
   int           lp_active, lp_len, lp_rem;
   int           n_checks, n_fail;
   bit           chk_en;

   function automatic int stored_cnt();
      return exp_q.size() + body_q.size();
   endfunction

   task automatic model_step();
      bit           can_wr, can_pop;
      int           was_active;
      logic [W-1:0] w;
      was_active = lp_active;
      can_wr  = inst_wr && (stored_cnt() < DEPTH);
      can_pop = inst_req && (exp_q.size() > 0);
      exp_valid = 1'b0;
      if (can_pop) begin
         w = exp_q.pop_front();
         exp_instruct = w;
         exp_valid = 1'b1;
         if (lp_active != 0) begin
            body_q.push_back(w);
            if (body_q.size() == lp_len) begin
               if (lp_rem > 0) begin
                  for (int i = body_q.size() - 1; i >= 0; i--) exp_q.push_front(body_q[i]);
                  lp_rem--;
               end else begin
                  lp_active = 0;
               end
               body_q.delete();
            end
         end
      end
      if (can_wr) exp_q.push_back(inst_wdata);
`ifdef INSTQ_LOOP_EN
      if (was_active == 0 && loop_start && loop_len >= 1 && loop_len <= DEPTH && loop_times >= 2) begin
         lp_active = 1;
         lp_len    = int'(loop_len);
         lp_rem    = int'(loop_times) - 1;
      end
`endif
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         body_q.delete();
         exp_instruct = '0;
         exp_valid    = 1'b0;
         lp_active    = 0;
         lp_len       = 0;
         lp_rem       = 0;
      end else begin
         model_step();
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("instruct", instruct, exp_instruct);
         chk("inst_valid", W'(inst_valid), W'(exp_valid));
         chk("inst_empty", W'(inst_empty), W'(exp_q.size() == 0));
         chk("inst_full", W'(inst_full), W'(stored_cnt() == DEPTH));
         chk("inst_count", W'(inst_count), W'(stored_cnt()));
`ifdef INSTQ_LOOP_EN
         chk("loop_busy", W'(loop_busy), W'(lp_active != 0));
`endif
      end
   end

   // ---------------- drivers ----------------
   task automatic set_idle();
      inst_wr    = 1'b0;
      inst_req   = 1'b0;
      inst_wdata = '0;
`ifdef INSTQ_LOOP_EN
      loop_start = 1'b0;
      loop_len   = '0;
      loop_times = '0;
`endif
   endtask

   task automatic step(input logic wr, input logic [W-1:0] d, input logic req);
      @(negedge clk);
      set_idle();
      inst_wr    = wr;
      inst_wdata = d;
      inst_req   = req;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      set_idle();
      rst = 1'b1;
      #1;
      chk("rst_empty", W'(inst_empty), W'(1));
      chk("rst_full", W'(inst_full), W'(0));
      chk("rst_count", W'(inst_count), W'(0));
      chk("rst_instruct", instruct, '0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

`ifdef INSTQ_LOOP_EN
   task automatic arm(input int len, input int times);
      @(negedge clk);
      set_idle();
      loop_start = 1'b1;
      loop_len   = (PTR_W+1)'(len);
      loop_times = CNT_W'(times);
      @(posedge clk);
      #1;
   endtask
`endif

   function automatic logic [W-1:0] rnd_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      chk_en   = 1'b0;
      set_idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Pop requests into an empty queue after reset are rejected.
      repeat (3) begin
         step(1'b0, '0, 1'b1);
         chk("idle_instruct", instruct, '0);
         chk("idle_valid", W'(inst_valid), W'(0));
         chk("idle_empty", W'(inst_empty), W'(1));
      end

      // Fill to DEPTH, overflow write dropped, drain in order.
      for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b0);
      step(1'b1, W'('h99), 1'b0);
      chk("fill_full", W'(inst_full), W'(1));
      chk("fill_count", W'(inst_count), W'(16));
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, '0, 1'b1);
         chk("drain_valid", W'(inst_valid), W'(1));
         chk("drain_data", instruct, W'(i));
      end
      chk("drain_empty", W'(inst_empty), W'(1));
      step(1'b0, '0, 1'b0);
      chk("hold_valid", W'(inst_valid), W'(0));
      chk("hold_data", instruct, W'('h10));

      // Write and pop together while full: the write loses.
      for (int i = 0; i < 16; i++) step(1'b1, W'('h30 + i), 1'b0);
      step(1'b1, W'('h20), 1'b1);
      chk("fullrw_count", W'(inst_count), W'(15));
      chk("fullrw_data", instruct, W'('h30));
      step(1'b1, W'('h20), 1'b0);
      chk("fullrw_retry", W'(inst_count), W'(16));
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
      chk("fullrw_last", instruct, W'('h20));

      // Interleaved traffic across the pointer wrap.
      for (int i = 0; i < 20; i++) step(1'b1, W'('h100 + i), (i % 3) == 2);
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
      chk("wrap_empty", W'(inst_empty), W'(1));

      // Randomized traffic with varied write/pop pressure.
      for (int ph = 0; ph < 4; ph++) begin
         int pw, pr;
         pw = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 60 : 100;
         pr = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 60 : 100;
         for (int c = 0; c < 500; c++) begin
`ifdef INSTQ_LOOP_EN
            if ($urandom_range(0, 39) == 0) begin
               arm(int'($urandom_range(0, DEPTH + 1)), int'($urandom_range(0, 3)));
               continue;
            end
`endif
            step($urandom_range(0, 99) < pw, rnd_word(), $urandom_range(0, 99) < pr);
         end
      end
      do_reset();

`ifdef INSTQ_LOOP_EN
      begin
         logic [W-1:0] abc[3];
         abc[0] = W'('hA);
         abc[1] = W'('hB);
         abc[2] = W'('hC);
         for (int i = 0; i < 3; i++) step(1'b1, abc[i], 1'b0);
         arm(3, 3);
         chk("loop_armed", W'(loop_busy), W'(1));
         for (int k = 0; k < 9; k++) begin
            step(1'b0, '0, 1'b1);
            chk("loop_data", instruct, abc[k % 3]);
            chk("loop_count", W'(inst_count), W'((k < 8) ? 3 : 0));
         end
         chk("loop_done", W'(loop_busy), W'(0));

         // Reset in the middle of the second pass.
         for (int i = 0; i < 3; i++) step(1'b1, abc[i], 1'b0);
         arm(3, 3);
         for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1);
         chk("loop_mid", instruct, abc[0]);
         @(negedge clk);
         set_idle();
         rst = 1'b1;
         #1;
         chk("lrst_busy", W'(loop_busy), W'(0));
         chk("lrst_empty", W'(inst_empty), W'(1));
         chk("lrst_instruct", instruct, '0);
         @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
         step(1'b0, '0, 1'b1);
         chk("lrst_after", W'(inst_count), W'(0));
      end
`endif

      repeat (2) step(1'b0, '0, 1'b0);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
